// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs decoded RV32I field bundles into 32-bit words
// and streams them into consecutive instruction-memory locations. It stops on
// the last bundle or when memory is full, then pulses done.
module instr_encode_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic              in_last,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic [1:0]        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [31:0]       L_BASE32 = BASE_ADDR;
  localparam logic [ADDR_W-1:0] L_BASE   = L_BASE32[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] L_TOP    = '1;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_cnt;
  logic [1:0]        r_err;
  // r_stop: program is over (last accepted or top address written);
  // the write cycle still runs, then the FSM leaves RUN.
  logic              r_stop;
  logic              r_full;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;

  logic              w_ready;
  logic              w_acc;
  logic              w_legal;
  logic              w_shift;
  logic [31:0]       w_enc;

  assign w_ready = (r_state == S_RUN) && !r_stop;
  assign w_acc   = in_valid && w_ready;
  assign w_legal = !(in_kind[2] && in_kind[1]);
  assign w_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // Field packing per opcode class; illegal kinds encode to zero (never written)
  always_comb begin
    w_enc = 32'h0;
    case (in_kind)
      3'd0: w_enc = {1'b0, in_funct7_5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'd1: w_enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      3'd2: w_enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      3'd3: w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                     in_imm[4:1], in_imm[11], 7'b1100011};
      3'd4: w_enc = {in_imm[31:12], in_rd, 7'b0110111};
      3'd5: begin
        if (w_shift)
          w_enc = {1'b0, in_funct7_5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      end
      default: w_enc = 32'h0;
    endcase
  end

  // Control FSM: address/count tracking, stop detection and sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= L_BASE;
      r_cnt   <= '0;
      r_err   <= 2'b00;
      r_stop  <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_addr  <= L_BASE;
            r_cnt   <= '0;
            r_err   <= 2'b00;
            r_stop  <= 1'b0;
            r_full  <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_stop) begin
            r_state <= S_DONE;
            if (r_full) r_err[1] <= 1'b1;
          end else if (w_acc) begin
            if (w_legal) begin
              r_addr <= r_addr + 1'b1;
              r_cnt  <= r_cnt + 1'b1;
              if (r_addr == L_TOP) begin
                r_full <= 1'b1;
                r_stop <= 1'b1;
              end
            end else begin
              r_err[0] <= 1'b1;
            end
            if (in_last) r_stop <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered memory write port: one strobe per accepted legal bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 32'h0;
    end else begin
      r_we <= w_acc && w_legal;
      if (w_acc && w_legal) begin
        r_waddr <= r_addr;
        r_wdata <= w_enc;
      end
    end
  end

  assign in_ready   = w_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_waddr;
  assign imem_wdata = r_wdata;
  assign count      = r_cnt;
  assign err        = r_err;
  assign done       = (r_state == S_DONE);

endmodule
